// File: rtl/seq_gen_prog.sv
// seq_gen_prog: run-time programmable sequence generator.
// Steps an index through a rewritable table of DEPTH codes (WIDTH bits each),
// forwards or backwards, over a programmable active length, and presents the
// code at that index as a registered stream.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous reset, active low
//   enable   advance one step per clock
//   up_down  1: increment index, 0: decrement
//   pp_mode  ping-pong request (used only when SEQ_PINGPONG_EN is defined)
//   wr_en    table write strobe; wr_addr/wr_data give entry and value
//   len_wr   active-length write strobe; len_in gives the new length
//   seq      current code (registered, always equals table[idx])
//   idx      current index (registered)
//   wrap     one-cycle pulse after a wrap or turnaround edge
//
// Build option: define SEQ_PINGPONG_EN to add ping-pong (bounce) stepping.
module seq_gen_prog #(
  parameter  int unsigned WIDTH = 5,
  parameter  int unsigned DEPTH = 6,
  localparam int unsigned AW    = $clog2(DEPTH),
  parameter  logic [WIDTH*DEPTH-1:0] INIT_TABLE = {WIDTH'(10), WIDTH'(7), WIDTH'(5),
                                                   WIDTH'(3),  WIDTH'(2), WIDTH'(0)}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             up_down,
  input  logic             pp_mode,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             len_wr,
  input  logic [AW:0]      len_in,
  output logic [WIDTH-1:0] seq,
  output logic [AW-1:0]    idx,
  output logic             wrap
);

  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] table_q [DEPTH];
  logic [WIDTH-1:0] table_d [DEPTH];
  logic [LW-1:0]    len_q, len_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] seq_q, seq_d;
  logic             wrap_q, wrap_d;
  logic [AW-1:0]    last;
  logic             step_up;

`ifdef SEQ_PINGPONG_EN
  // dir_q: current bounce direction; pp_load_q: up_down still to be sampled
  logic dir_q, dir_d;
  logic pp_load_q, pp_load_d;
`else
  logic unused_pp;
  assign unused_pp = pp_mode;
`endif

  // Next state: table write, then length update, then step
  always_comb begin
    table_d = table_q;
    len_d   = len_q;
    idx_d   = idx_q;
    wrap_d  = 1'b0;
    step_up = up_down;
`ifdef SEQ_PINGPONG_EN
    dir_d     = dir_q;
    pp_load_d = pp_load_q;
`endif

    if (wr_en && (32'(wr_addr) < DEPTH)) begin
      table_d[wr_addr] = wr_data;
    end

    if (len_wr) begin
      if (len_in == '0) begin
        len_d = LW'(1);
      end else if (32'(len_in) > DEPTH) begin
        len_d = LW'(DEPTH);
      end else begin
        len_d = len_in;
      end
    end

    // len_d is never 0, so last is a valid index
    last = AW'(len_d - LW'(1));

`ifdef SEQ_PINGPONG_EN
    if (!pp_mode) begin
      dir_d     = up_down;
      pp_load_d = 1'b1;
    end else if (!pp_load_q) begin
      step_up = dir_q;
    end
`endif

    if (enable) begin
`ifdef SEQ_PINGPONG_EN
      if (pp_mode) begin
        pp_load_d = 1'b0;
        if (len_d == LW'(1)) begin
          idx_d  = '0;
          wrap_d = 1'b1;
        end else begin
          // Moving outward from an end reverses instead of leaving the range
          if (step_up) begin
            idx_d = (idx_q >= last) ? idx_q - AW'(1) : idx_q + AW'(1);
          end else begin
            idx_d = (idx_q == '0) ? AW'(1) : idx_q - AW'(1);
          end
          // Landing on an end flips direction for the next step
          if (idx_d == last) begin
            dir_d  = 1'b0;
            wrap_d = 1'b1;
          end else if (idx_d == '0) begin
            dir_d  = 1'b1;
            wrap_d = 1'b1;
          end else begin
            dir_d = step_up;
          end
        end
      end else
`endif
      begin
        if (step_up) begin
          if (idx_q == last) begin
            idx_d  = '0;
            wrap_d = 1'b1;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end else begin
          if (idx_q == '0) begin
            idx_d  = last;
            wrap_d = 1'b1;
          end else begin
            idx_d = idx_q - AW'(1);
          end
        end
      end
    end

    // A shrinking length that strands the index restarts at entry 0
    if (len_wr && ((LW'(idx_q) >= len_d) || (LW'(idx_d) >= len_d))) begin
      idx_d  = '0;
      wrap_d = 1'b0;
    end

    // Write-through: code follows the freshly written table
    seq_d = table_d[idx_d];
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        table_q[i] <= INIT_TABLE[i*WIDTH +: WIDTH];
      end
      len_q  <= LW'(DEPTH);
      idx_q  <= '0;
      seq_q  <= INIT_TABLE[WIDTH-1:0];
      wrap_q <= 1'b0;
`ifdef SEQ_PINGPONG_EN
      dir_q     <= 1'b1;
      pp_load_q <= 1'b1;
`endif
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        table_q[i] <= table_d[i];
      end
      len_q  <= len_d;
      idx_q  <= idx_d;
      seq_q  <= seq_d;
      wrap_q <= wrap_d;
`ifdef SEQ_PINGPONG_EN
      dir_q     <= dir_d;
      pp_load_q <= pp_load_d;
`endif
    end
  end

  assign seq  = seq_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_seq_gen_prog.sv
// Testbench for seq_gen_prog (default parameters: WIDTH=5, DEPTH=6).
// Directed stimulus pushes hand-computed expectations into a queue; a monitor
// on the falling edge pops and compares them against seq/idx/wrap.
module tb_seq_gen_prog;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       up_down;
  logic       pp_mode;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [4:0] wr_data;
  logic       len_wr;
  logic [3:0] len_in;
  logic [4:0] seq;
  logic [2:0] idx;
  logic       wrap;

  typedef struct {
    logic [4:0] seq;
    logic [2:0] idx;
    logic       wrap;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  seq_gen_prog dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .up_down (up_down),
    .pp_mode (pp_mode),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .len_wr  (len_wr),
    .len_in  (len_in),
    .seq     (seq),
    .idx     (idx),
    .wrap    (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare every pending expectation on the falling edge
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      total++;
      if (seq !== mon_e.seq) begin
        bad++;
        $display("FAIL %s seq: got=%0d want=%0d", mon_e.tag, seq, mon_e.seq);
      end
      total++;
      if (idx !== mon_e.idx) begin
        bad++;
        $display("FAIL %s idx: got=%0d want=%0d", mon_e.tag, idx, mon_e.idx);
      end
      total++;
      if (wrap !== mon_e.wrap) begin
        bad++;
        $display("FAIL %s wrap: got=%0d want=%0d", mon_e.tag, wrap, mon_e.wrap);
      end
    end
  end

  task automatic push(input logic [4:0] es, input logic [2:0] ei, input logic ew,
                      input string tag);
    exp_t e;
    e.seq  = es;
    e.idx  = ei;
    e.wrap = ew;
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  // One clock with the given inputs; expectation is the state after the edge
  task automatic cyc(input logic en, input logic ud,
                     input logic we, input logic [2:0] wa, input logic [4:0] wd,
                     input logic lw, input logic [3:0] li,
                     input logic [4:0] es, input logic [2:0] ei, input logic ew,
                     input string tag);
    enable  = en;
    up_down = ud;
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    len_wr  = lw;
    len_in  = li;
    @(posedge clk);
    #1;
    push(es, ei, ew, tag);
  endtask

  // Plain enabled step
  task automatic st(input logic ud, input logic [4:0] es, input logic [2:0] ei,
                    input logic ew, input string tag);
    cyc(1'b1, ud, 1'b0, 3'd0, 5'd0, 1'b0, 4'd0, es, ei, ew, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; enable = 1'b0; up_down = 1'b1; pp_mode = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; len_wr = 1'b0; len_in = '0;

    // T1 reset, then count up through the initial table [0,2,3,5,7,10]
    repeat (5) begin
      @(posedge clk);
      #1;
      push(5'd0, 3'd0, 1'b0, "reset");
    end
    rst = 1'b1;
    st(1'b1, 5'd2,  3'd1, 1'b0, "t1_up1");
    st(1'b1, 5'd3,  3'd2, 1'b0, "t1_up2");
    st(1'b1, 5'd5,  3'd3, 1'b0, "t1_up3");
    st(1'b1, 5'd7,  3'd4, 1'b0, "t1_up4");
    st(1'b1, 5'd10, 3'd5, 1'b0, "t1_up5");
    st(1'b1, 5'd0,  3'd0, 1'b1, "t1_wrap");

    // T2 count down
    st(1'b0, 5'd10, 3'd5, 1'b1, "t2_wrap");
    st(1'b0, 5'd7,  3'd4, 1'b0, "t2_dn1");
    st(1'b0, 5'd5,  3'd3, 1'b0, "t2_dn2");
    st(1'b0, 5'd3,  3'd2, 1'b0, "t2_dn3");
    st(1'b0, 5'd2,  3'd1, 1'b0, "t2_dn4");
    st(1'b0, 5'd0,  3'd0, 1'b0, "t2_dn5");

    // T3 write-through and out-of-range writes
    st(1'b1, 5'd2, 3'd1, 1'b0, "t3_up1");
    st(1'b1, 5'd3, 3'd2, 1'b0, "t3_up2");
    cyc(1'b1, 1'b1, 1'b1, 3'd3, 5'd31, 1'b0, 4'd0, 5'd31, 3'd3, 1'b0, "t3_wthru");
    cyc(1'b1, 1'b1, 1'b1, 3'd7, 5'd9,  1'b0, 4'd0, 5'd7,  3'd4, 1'b0, "t3_wa7");
    cyc(1'b1, 1'b1, 1'b1, 3'd6, 5'd9,  1'b0, 4'd0, 5'd10, 3'd5, 1'b0, "t3_wa6");
    st(1'b1, 5'd0,  3'd0, 1'b1, "t3_wrap");
    st(1'b1, 5'd2,  3'd1, 1'b0, "t3_chk1");
    st(1'b1, 5'd3,  3'd2, 1'b0, "t3_chk2");
    st(1'b1, 5'd31, 3'd3, 1'b0, "t3_chk3");
    st(1'b1, 5'd7,  3'd4, 1'b0, "t3_chk4");

    // T4 length programming
    cyc(1'b1, 1'b1, 1'b0, 3'd0, 5'd0, 1'b1, 4'd3, 5'd0, 3'd0, 1'b0, "t4_len3");
    st(1'b1, 5'd2, 3'd1, 1'b0, "t4_l3_up1");
    st(1'b1, 5'd3, 3'd2, 1'b0, "t4_l3_up2");
    st(1'b1, 5'd0, 3'd0, 1'b1, "t4_l3_wrap");
    cyc(1'b1, 1'b1, 1'b0, 3'd0, 5'd0, 1'b1, 4'd0, 5'd0, 3'd0, 1'b1, "t4_len0");
    st(1'b1, 5'd0, 3'd0, 1'b1, "t4_l1_up");
    st(1'b0, 5'd0, 3'd0, 1'b1, "t4_l1_dn");
    cyc(1'b1, 1'b1, 1'b0, 3'd0, 5'd0, 1'b1, 4'd7, 5'd2, 3'd1, 1'b0, "t4_len7");
    st(1'b1, 5'd3,  3'd2, 1'b0, "t4_l6_up2");
    st(1'b1, 5'd31, 3'd3, 1'b0, "t4_l6_up3");
    st(1'b1, 5'd7,  3'd4, 1'b0, "t4_l6_up4");
    st(1'b1, 5'd10, 3'd5, 1'b0, "t4_l6_up5");
    st(1'b1, 5'd0,  3'd0, 1'b1, "t4_l6_wrap");

    // Write, length and step in the same edge
    cyc(1'b1, 1'b1, 1'b1, 3'd1, 5'd17, 1'b1, 4'd4, 5'd17, 3'd1, 1'b0, "combo");
    st(1'b1, 5'd3,  3'd2, 1'b0, "combo_up2");
    st(1'b1, 5'd31, 3'd3, 1'b0, "combo_up3");
    st(1'b1, 5'd0,  3'd0, 1'b1, "combo_wrap");

    // T5 hold, then asynchronous reset mid-cycle
    st(1'b1, 5'd17, 3'd1, 1'b0, "t5_up");
    repeat (4) cyc(1'b0, 1'b1, 1'b0, 3'd0, 5'd0, 1'b0, 4'd0, 5'd17, 3'd1, 1'b0, "t5_hold");
    enable = 1'b1;
    #6;
    rst = 1'b0;
    #1;
    push(5'd0, 3'd0, 1'b0, "t5_async_rst");
    @(posedge clk);
    #1;
    push(5'd0, 3'd0, 1'b0, "t5_rst_hold");
    rst = 1'b1;
    st(1'b1, 5'd2,  3'd1, 1'b0, "t5_tbl1");
    st(1'b1, 5'd3,  3'd2, 1'b0, "t5_tbl2");
    st(1'b1, 5'd5,  3'd3, 1'b0, "t5_tbl3");
    st(1'b1, 5'd7,  3'd4, 1'b0, "t5_tbl4");
    st(1'b1, 5'd10, 3'd5, 1'b0, "t5_tbl5");
    st(1'b1, 5'd0,  3'd0, 1'b1, "t5_wrap");

    // T6 ping-pong request over length 4
    cyc(1'b0, 1'b1, 1'b0, 3'd0, 5'd0, 1'b1, 4'd4, 5'd0, 3'd0, 1'b0, "t6_len4");
    pp_mode = 1'b1;
`ifdef SEQ_PINGPONG_EN
    st(1'b1, 5'd2, 3'd1, 1'b0, "t6_pp1");
    st(1'b1, 5'd3, 3'd2, 1'b0, "t6_pp2");
    st(1'b1, 5'd5, 3'd3, 1'b1, "t6_pp3");
    st(1'b1, 5'd3, 3'd2, 1'b0, "t6_pp4");
    st(1'b0, 5'd2, 3'd1, 1'b0, "t6_pp5");
    st(1'b1, 5'd0, 3'd0, 1'b1, "t6_pp6");
    st(1'b1, 5'd2, 3'd1, 1'b0, "t6_pp7");
`else
    st(1'b1, 5'd2, 3'd1, 1'b0, "t6_nopp1");
    st(1'b1, 5'd3, 3'd2, 1'b0, "t6_nopp2");
    st(1'b1, 5'd5, 3'd3, 1'b0, "t6_nopp3");
    st(1'b1, 5'd0, 3'd0, 1'b1, "t6_nopp4");
    st(1'b1, 5'd2, 3'd1, 1'b0, "t6_nopp5");
`endif
    enable  = 1'b0;
    pp_mode = 1'b0;

    // Drain outstanding expectations with a bounded wait
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got=%0d pending want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
